alu_ex_stage: RTL and testbench
===============================

# alu_ex_stage

Registered execute stage of the 8-bit RISC datapath, upstream of the writeback stage. Accepts one decoded ALU operation per handshake, performs add/subtract with the same two's-complement semantics as the AddSub_8bit adder, plus logic and iterative shift operations. Holds the processor's Z/N/C/V flag register so carry-chained operations (ADC/SBC) see the previous result's carry. Presents a registered result and flags to writeback over a valid/ready handshake.

## Interface
- SHIFT_W, 3: width of shift-amount field; shift amount is b[SHIFT_W-1:0].
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operation present.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  3  000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 AND, 101 OR, 110 SHL, 111 SHR (logical).
- in_a  in  8  operand A.
- in_b  in  8  operand B (shift amount for SHL/SHR).
- in_rd  in  3  destination register tag, passed through.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  writeback accepts result.
- out_result  out  8  registered result.
- out_rd  out  3  registered destination tag.
- out_flags  out  4  {Z,N,C,V} flag register.

## Operation
- States: IDLE, SHIFT. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept when in_valid && in_ready. Non-shift ops (and shifts with amount 0) load result, rd, flags and set out_valid at that edge; state stays IDLE.
- Shift with amount k>0: latch a, k, op, rd; go to SHIFT; shift one bit per cycle, decrement counter; on the edge where counter reaches 0, load result/flags, set out_valid, return to IDLE.
- out_valid clears on out_valid && out_ready unless a new result loads the same edge (then stays 1).
- Arithmetic, 9-bit internal sum: ADD a+b+0; SUB a+~b+1; ADC a+b+C; SBC a+~b+C. Result = sum[7:0]; C = sum[8] (for SUB/SBC, C=1 means no borrow); V = (a[7]==b'[7]) && (result[7]!=a[7]) where b' is the effective (possibly inverted) operand.
- Logic AND/OR: Z,N updated; V cleared; C unchanged.
- SHL/SHR: Z,N updated; V cleared; C = last bit shifted out; amount 0 returns a unchanged and leaves C unchanged.
- Z = (result==0); N = result[7]. Flags update only when a result loads.
- ADC/SBC read the flag register at accept; a result loading the same edge is the preceding op, so back-to-back chains are correct.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0x00, out_rd 0, out_flags 0000; in_ready 1 in the first cycle after reset.
- Latency accept -> out_valid: 1 cycle for ADD/SUB/ADC/SBC/AND/OR and zero-amount shifts; 1+k cycles for shift by k (max 8 with SHIFT_W=3, amount 7 -> 8).
- Throughput: one non-shift op per cycle while out_ready is held high.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and out_result/out_rd/out_flags hold stable.
- SHIFT state ignores in_valid; in_ready=0 throughout.
- rst asserted mid-shift aborts the shift; the partial result is discarded; all outputs return to reset values next edge.
- Overflow wrap: 8-bit result wraps modulo 256; no saturation.

## Configuration
- ALU_EX_FAST_SHIFT_EN defined: SHL/SHR done by a single-cycle barrel shifter; all ops latency 1; SHIFT state never entered; flags identical to the iterative form.
- Undefined: iterative one-bit-per-cycle shifter as above.

## Test plan
- After reset: out_valid=0, out_flags=0000, in_ready=1; ADD 0x7F+0x01 -> next cycle out_result=0x80, flags Z0 N1 C0 V1.
- SUB 0x05-0x05 -> 0x00, Z1 N0 C1 V0; SUB 0x00-0x01 -> 0xFF, Z0 N1 C0 V0.
- ADD 0xFF+0x01 (C=1) then ADC 0x00+0x00 back-to-back, out_ready=1 -> results 0x00 then 0x01; second flags C0.
- SHL 0x81 by 3 -> out_valid exactly 4 cycles after accept (1 with ALU_EX_FAST_SHIFT_EN), result 0x08, C=0; SHR 0x01 by 1 -> 0x00, Z1, C1.
- Hold out_ready=0 with result pending, drive in_valid=1 -> in_ready=0, outputs stable 5 cycles; raise out_ready -> new op accepted that edge.
- Assert rst during 7-bit shift at cycle 3 -> next edge out_valid=0, flags 0000, in_ready=1; no result emitted.

Source files
------------

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: registered 8-bit ALU execute stage with Z/N/C/V flag register and valid/ready handshakes.
// Define ALU_EX_FAST_SHIFT_EN for a single-cycle barrel shifter; by default shifts iterate one bit per cycle.
module alu_ex_stage #(
    parameter int SHIFT_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [2:0] in_rd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic [2:0] out_rd,
    output logic [3:0] out_flags
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    state_t state, next_state;

    logic               accept;
    logic               load_result;
    logic               start_shift;
    logic               shift_done;
    logic [SHIFT_W-1:0] amount;

    logic [7:0] b_eff;
    logic       cin;
    logic [8:0] sum;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_v;

    logic [7:0] step_val;
    logic       step_c;
    logic [2:0] step_rd;

    logic [7:0] res_next;
    logic [2:0] rd_next;
    logic       c_next;
    logic       v_next;

    assign amount   = in_b[SHIFT_W-1:0];
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ADC/SBC take carry from the flag register; it already holds the previous op's flags at accept.
    always_comb begin
        b_eff   = in_b;
        cin     = 1'b0;
        sum     = 9'h000;
        alu_res = 8'h00;
        alu_c   = out_flags[1];
        alu_v   = 1'b0;
        case (in_op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                b_eff   = in_op[0] ? ~in_b : in_b;
                cin     = in_op[1] ? out_flags[1] : in_op[0];
                sum     = {1'b0, in_a} + {1'b0, b_eff} + {8'h00, cin};
                alu_res = sum[7:0];
                alu_c   = sum[8];
                alu_v   = (in_a[7] == b_eff[7]) && (alu_res[7] != in_a[7]);
            end
            OP_AND: alu_res = in_a & in_b;
            OP_OR:  alu_res = in_a | in_b;
`ifdef ALU_EX_FAST_SHIFT_EN
            OP_SHL: begin
                if (amount != '0) begin
                    {alu_c, alu_res} = {1'b0, in_a} << amount;
                end else begin
                    alu_res = in_a;
                end
            end
            OP_SHR: begin
                if (amount != '0) begin
                    {alu_res, alu_c} = {in_a, 1'b0} >> amount;
                end else begin
                    alu_res = in_a;
                end
            end
`else
            OP_SHL, OP_SHR: alu_res = in_a;
`endif
            default: alu_res = 8'h00;
        endcase
    end

`ifdef ALU_EX_FAST_SHIFT_EN
    assign start_shift = 1'b0;
    assign shift_done  = 1'b0;
    assign step_val    = 8'h00;
    assign step_c      = 1'b0;
    assign step_rd     = 3'b000;
`else
    logic               is_shift;
    logic [7:0]         sh_val;
    logic [SHIFT_W-1:0] sh_cnt;
    logic               sh_left;
    logic [2:0]         sh_rd;

    assign is_shift    = (in_op == OP_SHL) || (in_op == OP_SHR);
    assign start_shift = accept && is_shift && (amount != '0);
    assign shift_done  = (state == SHIFT) && (sh_cnt == SHIFT_W'(1));
    assign step_val    = sh_left ? {sh_val[6:0], 1'b0} : {1'b0, sh_val[7:1]};
    assign step_c      = sh_left ? sh_val[7] : sh_val[0];
    assign step_rd     = sh_rd;

    // The final bit moves on the same edge that loads the result, so the carry comes straight from step_c.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_val  <= 8'h00;
            sh_cnt  <= '0;
            sh_left <= 1'b0;
            sh_rd   <= 3'b000;
        end else if (start_shift) begin
            sh_val  <= in_a;
            sh_cnt  <= amount;
            sh_left <= (in_op == OP_SHL);
            sh_rd   <= in_rd;
        end else if (state == SHIFT) begin
            sh_val  <= step_val;
            sh_cnt  <= sh_cnt - SHIFT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_shift) next_state = SHIFT;
            SHIFT:   if (shift_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_result = (accept && !start_shift) || shift_done;
        res_next    = shift_done ? step_val : alu_res;
        rd_next     = shift_done ? step_rd : in_rd;
        c_next      = shift_done ? step_c : alu_c;
        v_next      = shift_done ? 1'b0 : alu_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 8'h00;
            out_rd     <= 3'b000;
            out_flags  <= 4'b0000;
        end else if (load_result) begin
            out_valid  <= 1'b1;
            out_result <= res_next;
            out_rd     <= rd_next;
            out_flags  <= {(res_next == 8'h00), res_next[7], c_next, v_next};
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: directed and random stimulus with a scoreboard of expected results for alu_ex_stage.
`timescale 1ns/1ps
module tb_alu_ex_stage;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_ADC = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

`ifdef ALU_EX_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
    localparam int SHL3_LATENCY = 1;
`else
    localparam bit FAST = 1'b0;
    localparam int SHL3_LATENCY = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_rd;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_rd;
    logic [3:0] out_flags;

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_q[$];
    logic [14:0] exp_item;
    logic [3:0]  model_flags;

    alu_ex_stage #(.SHIFT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_rd    (out_rd),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model in integer arithmetic; returns {result, Z, N, C, V}.
    function automatic logic [11:0] modelOp(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [3:0] fl);
        int ia, ib, sa, sb, cf, r, sr, k;
        logic [31:0] rbits;
        logic [7:0] res;
        logic c, v;
        ia = int'(a);
        ib = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        cf = fl[1] ? 1 : 0;
        k  = int'(b[2:0]);
        c  = fl[1];
        v  = 1'b0;
        r  = 0;
        sr = 0;
        case (op)
            OP_ADD: begin r = ia + ib;          c = (r > 255); sr = sa + sb; end
            OP_SUB: begin r = ia - ib;          c = (r >= 0);  sr = sa - sb; end
            OP_ADC: begin r = ia + ib + cf;     c = (r > 255); sr = sa + sb + cf; end
            OP_SBC: begin r = ia - ib - 1 + cf; c = (r >= 0);  sr = sa - sb - 1 + cf; end
            OP_AND: r = ia & ib;
            OP_OR:  r = ia | ib;
            OP_SHL: begin
                r = ia << k;
                rbits = r;
                if (k != 0) c = rbits[8];
            end
            default: begin
                r = ia >> k;
                if (k != 0) c = a[k-1];
            end
        endcase
        if (op <= OP_SBC) v = (sr > 127) || (sr < -128);
        rbits = r;
        res = rbits[7:0];
        return {res, (res == 8'h00), res[7], c, v};
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] rd, input bit expect_result);
        int waited;
        logic [11:0] m;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (expect_result) begin
            m = modelOp(op, a, b, model_flags);
            model_flags = m[3:0];
            exp_q.push_back({rd, m});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_queue", exp_q.size(), 0);
        checkOutput("drain_valid", {31'b0, out_valid}, 32'd0);
    endtask

    // Scoreboard: a transfer happens at the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", {31'b0, out_valid}, 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                checkOutput("scoreboard", {17'b0, out_rd, out_result, out_flags}, {17'b0, exp_item});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int lat;
        int seen;
        logic [2:0] rop;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_op       = 3'd0;
        in_a        = 8'h00;
        in_b        = 8'h00;
        in_rd       = 3'd0;
        out_ready   = 1'b1;
        model_flags = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_flags", {28'b0, out_flags}, 32'h0);
        checkOutput("reset_result", {24'b0, out_result}, 32'h0);
        checkOutput("reset_rd", {29'b0, out_rd}, 32'h0);
        checkOutput("reset_ready", {31'b0, in_ready}, 32'd1);

        applyStimulus(OP_ADD, 8'h7F, 8'h01, 3'd1, 1'b1);
        checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("add_result", {24'b0, out_result}, 32'h80);
        checkOutput("add_flags", {28'b0, out_flags}, 32'b0101);

        applyStimulus(OP_SUB, 8'h05, 8'h05, 3'd2, 1'b1);
        checkOutput("sub_eq_result", {24'b0, out_result}, 32'h00);
        checkOutput("sub_eq_flags", {28'b0, out_flags}, 32'b1010);
        applyStimulus(OP_SUB, 8'h00, 8'h01, 3'd3, 1'b1);
        checkOutput("sub_borrow_result", {24'b0, out_result}, 32'hFF);
        checkOutput("sub_borrow_flags", {28'b0, out_flags}, 32'b0100);

        applyStimulus(OP_ADD, 8'hFF, 8'h01, 3'd4, 1'b1);
        checkOutput("chain_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("chain_add_flags", {28'b0, out_flags}, 32'b1010);
        applyStimulus(OP_ADC, 8'h00, 8'h00, 3'd5, 1'b1);
        checkOutput("chain_adc_result", {24'b0, out_result}, 32'h01);
        checkOutput("chain_adc_carry", {31'b0, out_flags[1]}, 32'd0);
        drain();

        applyStimulus(OP_SHL, 8'h81, 8'h03, 3'd6, 1'b1);
        checkOutput("shift_ready", {31'b0, in_ready}, FAST ? 32'd1 : 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("shl_latency", lat, SHL3_LATENCY);
        checkOutput("shl_result", {24'b0, out_result}, 32'h08);
        checkOutput("shl_carry", {31'b0, out_flags[1]}, 32'd0);
        drain();
        applyStimulus(OP_SHR, 8'h01, 8'h01, 3'd7, 1'b1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("shr_result", {24'b0, out_result}, 32'h00);
        checkOutput("shr_flags", {28'b0, out_flags}, 32'b1010);
        drain();

        out_ready = 1'b0;
        applyStimulus(OP_ADD, 8'h10, 8'h20, 3'd3, 1'b1);
        in_valid = 1'b1;
        in_op    = OP_OR;
        in_a     = 8'h0F;
        in_b     = 8'hF0;
        in_rd    = 3'd4;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_hold", {17'b0, out_valid, out_rd, out_result, out_flags},
                        {17'b0, 1'b1, 3'd3, 8'h30, 4'b0000});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
        exp_q.push_back({3'd4, modelOp(OP_OR, 8'h0F, 8'hF0, model_flags)});
        model_flags = modelOp(OP_OR, 8'h0F, 8'hF0, model_flags) & 12'h00F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp_new_result", {21'b0, out_rd, out_result}, {21'b0, 3'd4, 8'hFF});
        checkOutput("bp_new_flags", {28'b0, out_flags}, 32'b0100);
        drain();

        applyStimulus(OP_SHL, 8'h01, 8'h07, 3'd5, FAST);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_flags", {28'b0, out_flags}, 32'h0);
        checkOutput("abort_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        exp_q.delete();
        model_flags = 4'b0000;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("abort_no_result", seen, 0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            applyStimulus(rop, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          3'($urandom_range(0, 7)), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
